// File: rtl/image_brightness_adjust.sv
// Purpose : per-pixel brightness add/subtract with clamping, raster position tags and per-frame clip count.
// Latency : 1 cycle from input acceptance to m_valid; full rate of 1 pixel/cycle.
// Backpressure: single output register; s_ready = !m_valid || m_ready, and data/flags hold while stalled.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_offset/mode   brightness offset and direction (1 = add, 0 = subtract), captured on the first beat of a frame
//   s_valid/ready/data  upstream pixel stream, channel 0 in the LSBs
//   m_valid/ready/data  downstream adjusted pixel stream
//   m_sof/eol/eof     frame start, line end and frame end tags travelling with m_data
//   clip_count        clipped channel samples in the last completed frame
//   frame_done        one-cycle pulse when clip_count is updated (at acceptance of the last pixel)
module image_brightness_adjust #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 512,
    parameter int HEIGHT   = 768,
    parameter int CNT_W    = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            cfg_offset,
    input  logic                         cfg_mode,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [CHANNELS*DATA_W-1:0]   s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [CHANNELS*DATA_W-1:0]   m_data,
    output logic                         m_sof,
    output logic                         m_eol,
    output logic                         m_eof,
    output logic [CNT_W-1:0]             clip_count,
    output logic                         frame_done
);

    localparam int COL_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CLIP_W = $clog2(CHANNELS + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                         m_valid_q;
    logic [CHANNELS*DATA_W-1:0]   m_data_q;
    logic                         m_sof_q;
    logic                         m_eol_q;
    logic                         m_eof_q;
    logic [COL_W-1:0]             col_q,  col_d;
    logic [ROW_W-1:0]             row_q,  row_d;
    logic [DATA_W-1:0]            off_q;
    logic                         mode_q;
    logic [CNT_W-1:0]             acc_q,  acc_d;
    logic [CNT_W-1:0]             clip_q;
    logic                         frame_done_q;

    // ------------------------------------------------------------------
    // Handshake and position decode
    // ------------------------------------------------------------------
    logic beat_acc;
    logic at_sof;
    logic at_eol;
    logic at_eof;

    assign s_ready  = !m_valid_q || m_ready;
    assign beat_acc = s_valid && s_ready;

    assign at_sof = (col_q == '0) && (row_q == '0);
    assign at_eol = (col_q == COL_LAST);
    assign at_eof = at_eol && (row_q == ROW_LAST);

    // The first beat of a frame must already see the new configuration,
    // so it bypasses the latch and uses the live inputs.
    logic [DATA_W-1:0] off_eff;
    logic              mode_eff;

    assign off_eff  = at_sof ? cfg_offset : off_q;
    assign mode_eff = at_sof ? cfg_mode   : mode_q;

    // ------------------------------------------------------------------
    // Per-channel clamped add/subtract
    // ------------------------------------------------------------------
    logic [CHANNELS*DATA_W-1:0] adj_dat;
    logic [CHANNELS-1:0]        clip_vec;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_W-1:0] x;
        logic [DATA_W:0]   sum;
        logic [DATA_W:0]   dif;

        assign x   = s_data[c*DATA_W +: DATA_W];
        assign sum = {1'b0, x} + {1'b0, off_eff};
        // Top bit of dif is the borrow: set exactly when x < offset.
        assign dif = {1'b0, x} - {1'b0, off_eff};

        // Carry/borrow out is both the clamp select and the clip event;
        // x == offset (decrease) or x + offset == max (increase) lands
        // exactly on the rail without a carry/borrow and is not a clip.
        assign adj_dat[c*DATA_W +: DATA_W] =
            mode_eff ? (sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0])
                     : (dif[DATA_W] ? {DATA_W{1'b0}} : dif[DATA_W-1:0]);

        assign clip_vec[c] = mode_eff ? sum[DATA_W] : dif[DATA_W];
    end

    // Number of clipped channels in the current beat.
    logic [CLIP_W-1:0] beat_clips;

    always_comb begin
        beat_clips = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            beat_clips = beat_clips + CLIP_W'(clip_vec[i]);
        end
    end

    // ------------------------------------------------------------------
    // Saturating clip accumulator
    // ------------------------------------------------------------------
    logic [CNT_W:0]   acc_sum;
    logic [CNT_W-1:0] acc_sat;

    assign acc_sum = {1'b0, acc_q} + (CNT_W+1)'(beat_clips);
    assign acc_sat = acc_sum[CNT_W] ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];

    // The EOF beat hands its total to clip_count and restarts the count.
    always_comb begin
        acc_d = acc_q;
        if (beat_acc) begin
            acc_d = at_eof ? '0 : acc_sat;
        end
    end

    // ------------------------------------------------------------------
    // Raster position counters
    // ------------------------------------------------------------------
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (beat_acc) begin
            if (at_eol) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_sof_q      <= 1'b0;
            m_eol_q      <= 1'b0;
            m_eof_q      <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            off_q        <= '0;
            mode_q       <= 1'b0;
            acc_q        <= '0;
            clip_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            acc_q        <= acc_d;
            frame_done_q <= beat_acc && at_eof;

            if (beat_acc) begin
                m_valid_q <= 1'b1;
                m_data_q  <= adj_dat;
                m_sof_q   <= at_sof;
                m_eol_q   <= at_eol;
                m_eof_q   <= at_eof;
            end else if (m_ready) begin
                // Output drained with nothing new behind it; data is left
                // as-is since it is qualified by m_valid.
                m_valid_q <= 1'b0;
            end

            if (beat_acc && at_sof) begin
                off_q  <= cfg_offset;
                mode_q <= cfg_mode;
            end

            if (beat_acc && at_eof) begin
                clip_q <= acc_sat;
            end
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_sof      = m_sof_q;
    assign m_eol      = m_eol_q;
    assign m_eof      = m_eof_q;
    assign clip_count = clip_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_image_brightness_adjust.sv
module tb_image_brightness_adjust;

    localparam int DW = 8;
    localparam int CH = 3;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CW = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   cfg_offset;
    logic            cfg_mode;
    logic            s_valid;
    logic            s_ready;
    logic [CH*DW-1:0] s_data;
    logic            m_valid;
    logic            m_ready;
    logic [CH*DW-1:0] m_data;
    logic            m_sof;
    logic            m_eol;
    logic            m_eof;
    logic [CW-1:0]   clip_count;
    logic            frame_done;

    image_brightness_adjust #(
        .DATA_W(DW), .CHANNELS(CH), .WIDTH(W), .HEIGHT(H), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_offset(cfg_offset), .cfg_mode(cfg_mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .clip_count(clip_count), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fd_seen = 0;
    int n_eof = 0;
    int tb_col = 0;
    int tb_row = 0;

    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [23:0] dat;
        logic [2:0]  flg;   // {sof, eol, eof}
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [23:0] pix;
        logic [7:0]  off;
        logic        mode;
        logic [23:0] exp_pix;
        int          clips;   // clipped channels per pixel
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Independent integer reference for the hand-written sequences.
    function automatic logic [23:0] ref_px(input logic [23:0] p, input int o, input bit m);
        logic [23:0] r;
        int x, y;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            x = int'(p[c*8 +: 8]);
            if (m) y = (x + o > 255) ? 255 : x + o;
            else   y = (x > o) ? x - o : 0;
            r[c*8 +: 8] = 8'(y);
        end
        return r;
    endfunction

    function automatic int ref_clips(input logic [23:0] p, input int o, input bit m);
        int x, n;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            x = int'(p[c*8 +: 8]);
            if (m && (x + o > 255)) n++;
            if (!m && (x < o)) n++;
        end
        return n;
    endfunction

    // Output monitor: pops the scoreboard on every output transfer and,
    // while stalled, checks the held beat against the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got data 0x%0h, expected no beat", m_data);
            end else begin
                e = sb.pop_front();
                chk("m_data", m_data, e.dat);
                chk("m_flags", {m_sof, m_eol, m_eof}, e.flg);
            end
        end else if (m_valid && !m_ready && sb.size() > 0) begin
            chk("stall_data", m_data, sb[0].dat);
            chk("stall_flags", {m_sof, m_eol, m_eof}, sb[0].flg);
        end
        if (frame_done) fd_seen++;
    end

    // Drive one beat and wait (bounded) for acceptance; the expected output
    // and its position tags enter the scoreboard at acceptance.
    task automatic send_beat(input logic [23:0] pix, input logic [23:0] expd);
        exp_t e;
        int k;
        s_valid = 1'b1;
        s_data  = pix;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_ready) break;
        end
        if (k == 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: s_ready low for 100 cycles, expected acceptance");
        end else begin
            e.dat = expd;
            e.flg = {(tb_col == 0 && tb_row == 0), (tb_col == W-1), (tb_col == W-1 && tb_row == H-1)};
            if (e.flg[0]) n_eof++;
            sb.push_back(e);
            if (tb_col == W-1) begin
                tb_col = 0;
                tb_row = (tb_row == H-1) ? 0 : tb_row + 1;
            end else begin
                tb_col++;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Called 1 time unit after the EOF beat's acceptance edge.
    task automatic check_eof(input int exp_clips);
        chk("frame_done_at_eof", frame_done, 1);
        chk("clip_count", clip_count, exp_clips);
        @(posedge clk);
        #1;
        chk("frame_done_one_cycle", frame_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int clips;
        logic [23:0] p;

        vt[0] = '{ {8'd200, 8'd50,  8'd10},  8'd50,  1'b0, {8'd150, 8'd0,   8'd0},   1 };
        vt[1] = '{ {8'd200, 8'd155, 8'd0},   8'd100, 1'b1, {8'd255, 8'd255, 8'd100}, 1 };
        vt[2] = '{ {8'd255, 8'd0,   8'd77},  8'd0,   1'b1, {8'd255, 8'd0,   8'd77},  0 };
        vt[3] = '{ {8'd0,   8'd128, 8'd255}, 8'd0,   1'b0, {8'd0,   8'd128, 8'd255}, 0 };
        vt[4] = '{ {8'd255, 8'd254, 8'd0},   8'd255, 1'b0, {8'd0,   8'd0,   8'd0},   2 };
        vt[5] = '{ {8'd0,   8'd1,   8'd255}, 8'd255, 1'b1, {8'd255, 8'd255, 8'd255}, 2 };
        vt[6] = '{ {8'd254, 8'd255, 8'd100}, 8'd1,   1'b1, {8'd255, 8'd255, 8'd101}, 1 };
        vt[7] = '{ {8'd1,   8'd0,   8'd2},   8'd1,   1'b0, {8'd0,   8'd0,   8'd1},   1 };

        rst        = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        m_ready    = 1'b1;
        cfg_offset = '0;
        cfg_mode   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_flags", {m_sof, m_eol, m_eof}, 0);
        chk("rst_clip_count", clip_count, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_s_ready", s_ready, 1);
        rst = 1'b0;

        // Table: one full 4x2 frame per record, back-to-back beats
        for (int r = 0; r < 8; r++) begin
            cfg_offset = vt[r].off;
            cfg_mode   = vt[r].mode;
            t0 = cyc;
            for (int b = 0; b < W*H; b++) send_beat(vt[r].pix, vt[r].exp_pix);
            chk("throughput_cycles", cyc - t0, W*H);
            check_eof(W*H*vt[r].clips);
        end

        // Backpressure: m_ready low for ~5 cycles while a frame is offered
        cfg_offset = 8'd50;
        cfg_mode   = 1'b0;
        m_ready    = 1'b0;
        clips      = 0;
        fork
            begin
                for (int i = 0; i < W*H; i++) begin
                    p = {8'(i*37), 8'(255 - i*20), 8'(i*9)};
                    clips += ref_clips(p, 50, 1'b0);
                    send_beat(p, ref_px(p, 50, 1'b0));
                end
            end
            begin
                repeat (2) @(negedge clk);
                chk("stall_s_ready", s_ready, 0);
                repeat (3) @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        check_eof(clips);

        // Mid-frame configuration change only takes effect at the next frame
        cfg_offset = 8'd20;
        cfg_mode   = 1'b0;
        p = {8'd100, 8'd40, 8'd10};
        for (int b = 0; b < W*H; b++) begin
            if (b == 3) cfg_offset = 8'd60;
            if (b == 4) cfg_mode = 1'b1;
            if (b == 7) cfg_mode = 1'b0;
            send_beat(p, {8'd80, 8'd20, 8'd0});
        end
        check_eof(8);
        for (int b = 0; b < W*H; b++) send_beat(p, {8'd40, 8'd0, 8'd0});
        check_eof(16);

        // Reset mid-frame after 5 beats
        cfg_offset = 8'd50;
        cfg_mode   = 1'b0;
        for (int b = 0; b < 5; b++) send_beat({8'd200, 8'd50, 8'd10}, {8'd150, 8'd0, 8'd0});
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_flags", {m_sof, m_eol, m_eof}, 0);
        chk("midrst_clip_count", clip_count, 0);
        chk("midrst_frame_done", frame_done, 0);
        rst = 1'b0;
        sb.delete();
        tb_col = 0;
        tb_row = 0;
        cfg_offset = 8'd7;
        cfg_mode   = 1'b1;
        for (int b = 0; b < W*H; b++) send_beat({8'd250, 8'd3, 8'd0}, {8'd255, 8'd10, 8'd7});
        check_eof(8);

        // Drain and final accounting
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        chk("frame_done_pulses", fd_seen, n_eof);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
